keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad responder: the device at the far end of the keypad scanner's row/column interface.
- Accepts key-press commands over a valid/ready handshake.
- Models the switch contact: bounce on press, a clean hold, bounce on release, then an inter-key gap.
- Drives the column lines in response to whichever row the scanner is driving.
- Used for on-board self-test and as a bench stimulus for the scanner/debouncer in top.

Parameters:
- HOLD_W, 24: width of hold_cycles.
- BOUNCE_CYCLES, 48000: cycles of contact chatter on each edge (1 ms at 48 MHz). 0 disables bounce.
- GAP_CYCLES, 48000: cycles of guaranteed open contact after release, before the next command is accepted. Must be ≥1.
- LFSR_SEED, 16'hACE1: nonzero reset value of the chatter LFSR.

Ports:
- clk, input, 1: system clock (HSOSC, 48 MHz).
- reset, input, 1: asynchronous, active-low reset.
- press_valid, input, 1: command valid.
- press_ready, output, 1: ready to accept a command. High only in IDLE.
- press_key, input, 4: key position. [3:2] = row index r, [1:0] = column index c.
- hold_cycles, input, HOLD_W: clean-closed duration. 0 is treated as 1.
- rows, input, 4: active-high row drive from the scanner.
- cols, output, 4: active-high column sense to the scanner.
- busy, output, 1: high whenever state ≠ IDLE.
- done, output, 1: one-cycle pulse when a press sequence completes.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, contact=0, all counters=0, LFSR=LFSR_SEED.
  - cols=0, press_ready=1, busy=0, done=0.
- Handshake:
  - A command is accepted on a rising clk edge with press_valid & press_ready.
  - press_key is latched to r_q/c_q and hold_cycles to hold_q at acceptance.
  - Inputs are ignored while busy. press_valid held high while busy is not an error.
- Column output is combinational from rows: cols = contact ? ({3'b0, rows[r_q]} << c_q) : 4'b0.
  - Only row r_q can close column c_q. All other cols bits are always 0.
  - If several rows are driven, only rows[r_q] matters.
- contact is a registered bit. The LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11, and advances every cycle in every state.
- FSM (one transition per clk):
  - IDLE: contact=0. On accept: go to BOUNCE_IN with cnt=0, or to HOLD if BOUNCE_CYCLES==0.
  - BOUNCE_IN: contact ← lfsr[0] each cycle. cnt increments. When cnt==BOUNCE_CYCLES-1: contact←1, cnt←0, go to HOLD.
  - HOLD: contact=1. When cnt==max(hold_q,1)-1: cnt←0, go to BOUNCE_OUT, or to GAP with contact←0 if BOUNCE_CYCLES==0.
  - BOUNCE_OUT: contact ← lfsr[0]. When cnt==BOUNCE_CYCLES-1: contact←0, cnt←0, go to GAP.
  - GAP: contact=0. When cnt==GAP_CYCLES-1: go to IDLE and assert done for that one cycle.
- Clean-closed time is exactly max(hold_q,1) cycles. Total busy time is 2·BOUNCE_CYCLES + max(hold_q,1) + GAP_CYCLES cycles.
- done and press_ready:
  - done is registered and asserted the cycle the state becomes IDLE.
  - press_ready is also high in that cycle, so back-to-back commands are accepted in the same cycle done is high.
- Counters:
  - cnt width = max($clog2(BOUNCE_CYCLES+1), $clog2(GAP_CYCLES+1), HOLD_W).
  - cnt never wraps; every compare is equality against a value the counter reaches.
- Reset mid-operation (any state): immediate contact=0 and cols=0. The in-flight command is dropped and done is not pulsed.

Decomposition:
- Shared package keypad_pkg:
  - typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} emu_state_t.
  - typedef struct packed {logic [1:0] row; logic [1:0] col;} key_pos_t. press_key casts to it.
  - localparam LFSR_TAPS.
- One sub-module, lfsr16:
  - Ports: clk, reset, seed parameter, q[15:0].
  - Free-running.
  - Reused by the scanner bench for random stimulus.

Test Plan:
- Reset and idle: reset low, rows=4'b1111 → cols=0, press_ready=1, busy=0. Release reset → unchanged until a command is accepted.
- Clean press with BOUNCE_CYCLES=0, GAP_CYCLES=4:
  - Stimulus: press_key=4'b0110 (r=1, c=2), hold_cycles=10, rows cycling one-hot.
  - Required: cols=4'b0100 exactly when rows[1]=1, for 10 cycles. Then 4 gap cycles, then done pulses once. Total busy 14 cycles.
- Bounce with BOUNCE_CYCLES=8, seed ACE1:
  - Stimulus: rows held at 4'b0001, press_key=4'b0000.
  - Required: cols[0] matches the golden LFSR bit stream for 8 cycles, is steady 1 for the hold, matches the LFSR again for 8 cycles, then 0.
- Row mismatch: press_key=4'b1111 with rows=4'b0111 throughout → cols stays 0 for the entire sequence. done still pulses.
- Handshake:
  - Second command with press_valid high during busy → ignored.
  - Accepted in the done cycle → busy stays 1 with no IDLE gap.
  - hold_cycles=0 → 1-cycle hold.
- Reset mid-HOLD: reset asserted asynchronously between clk edges → cols drops to 0 before the next edge, no done pulse, press_ready=1 after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
// Imported by the emulator top and its chatter LFSR.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Fibonacci taps 16,14,13,11 on a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the contact-chatter source.
// Also reused by the scanner bench for random stimulus.
module lfsr16
    import keypad_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: closes one row/column crosspoint per command,
// with LFSR chatter on press and release and a guaranteed open gap afterwards.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int          HOLD_W        = 24,
    parameter int          BOUNCE_CYCLES = 48000,
    parameter int          GAP_CYCLES    = 48000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              press_valid,
    output logic              press_ready,
    input  logic [3:0]        press_key,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [3:0]        rows,
    output logic [3:0]        cols,
    output logic              busy,
    output logic              done
);

    localparam int CW = max3($clog2(BOUNCE_CYCLES + 1),
                             $clog2(GAP_CYCLES + 1), HOLD_W);
    localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);
    localparam logic [CW-1:0] B_LAST = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    emu_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              contact_q, contact_d;
    logic              done_q, done_d;
    key_pos_t          key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_last;
    logic [15:0]       lfsr_q;
    logic              unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:1];

    // A zero hold is stretched to a single clean-closed cycle
    assign hold_last = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);

    assign press_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign cols        = contact_q ? ({3'b0, rows[key_q.row]} << key_q.col)
                                   : 4'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        key_d     = key_q;
        hold_d    = hold_q;
        unique case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                if (press_valid) begin
                    key_d  = key_pos_t'(press_key);
                    hold_d = hold_cycles;
                    cnt_d  = '0;
                    if (NO_BOUNCE) begin
                        state_d   = HOLD;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = BOUNCE_IN;
                        contact_d = lfsr_q[0];
                    end
                end
            end
            BOUNCE_IN: begin
                cnt_d     = cnt_q + CW'(1);
                contact_d = lfsr_q[0];
                if (cnt_q == B_LAST) begin
                    cnt_d     = '0;
                    contact_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                cnt_d     = cnt_q + CW'(1);
                contact_d = 1'b1;
                if (cnt_q == CW'(hold_last)) begin
                    cnt_d = '0;
                    if (NO_BOUNCE) begin
                        state_d   = GAP;
                        contact_d = 1'b0;
                    end else begin
                        state_d   = BOUNCE_OUT;
                        contact_d = lfsr_q[0];
                    end
                end
            end
            BOUNCE_OUT: begin
                cnt_d     = cnt_q + CW'(1);
                contact_d = lfsr_q[0];
                if (cnt_q == B_LAST) begin
                    cnt_d     = '0;
                    contact_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                cnt_d     = cnt_q + CW'(1);
                contact_d = 1'b0;
                if (cnt_q == G_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                contact_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one clean (no bounce) instance and
// one bouncing instance checked against an independent LFSR bit stream.
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pv_a, pv_b;
    logic [3:0]  key;
    logic [23:0] hold;
    logic [3:0]  rows;
    logic        rdy_a, busy_a, done_a;
    logic        rdy_b, busy_b, done_b;
    logic [3:0]  cols_a, cols_b;
    logic [3:0]  exp;
    logic [15:0] gold;
    logic        gbit;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_W        (24),
        .BOUNCE_CYCLES (0),
        .GAP_CYCLES    (4),
        .LFSR_SEED     (16'hACE1)
    ) u_clean (
        .clk         (clk),
        .reset       (reset),
        .press_valid (pv_a),
        .press_ready (rdy_a),
        .press_key   (key),
        .hold_cycles (hold),
        .rows        (rows),
        .cols        (cols_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    keypad_emulator #(
        .HOLD_W        (24),
        .BOUNCE_CYCLES (8),
        .GAP_CYCLES    (4),
        .LFSR_SEED     (16'hACE1)
    ) u_bnc (
        .clk         (clk),
        .reset       (reset),
        .press_valid (pv_b),
        .press_ready (rdy_b),
        .press_key   (key),
        .hold_cycles (hold),
        .rows        (rows),
        .cols        (cols_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    // Golden chatter stream: gbit is the bit the emulator latches at each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            gold <= 16'hACE1;
            gbit <= 1'b0;
        end else begin
            gold <= {gold[14:0], gold[15] ^ gold[13] ^ gold[12] ^ gold[10]};
            gbit <= gold[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    initial begin
        pv_a = 1'b0;
        pv_b = 1'b0;
        key  = 4'b0;
        hold = 24'd0;
        rows = 4'b1111;

        // reset and idle
        #12;
        chk("rst_cols_a", cols_a, 4'b0);
        chk("rst_cols_b", cols_b, 4'b0);
        chk("rst_ready", rdy_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready_b", rdy_b, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cols", cols_a, 4'b0);
        chk("idle_ready", rdy_a, 1);
        chk("idle_busy", busy_a, 0);
        chk("idle_done_b", done_b, 0);

        // clean press r=1 c=2, hold 10, rows cycling one-hot
        key  = 4'b0110;
        hold = 24'd10;
        pv_a = 1'b1;
        rows = 4'b0001;
        @(negedge clk);
        pv_a = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rows = 4'(4'b0001 << (i % 4));
            #1;
            exp = (i < 10 && rows[1]) ? 4'b0100 : 4'b0000;
            chk("clean_cols", cols_a, exp);
            chk("clean_busy", busy_a, 1);
            @(negedge clk);
        end
        chk("clean_done", done_a, 1);
        chk("clean_ready", rdy_a, 1);
        chk("clean_idle", busy_a, 0);
        @(negedge clk);
        chk("clean_done_once", done_a, 0);

        // bounce: 8 chatter, 5 hold, 8 chatter, 4 gap
        rows = 4'b0001;
        key  = 4'b0000;
        hold = 24'd5;
        pv_b = 1'b1;
        @(negedge clk);
        pv_b = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i < 8 || (i >= 13 && i < 21))
                exp = {3'b0, gbit};
            else if (i < 13)
                exp = 4'b0001;
            else
                exp = 4'b0000;
            chk("bounce_cols", cols_b, exp);
            chk("bounce_busy", busy_b, 1);
            @(negedge clk);
        end
        chk("bounce_done", done_b, 1);
        chk("bounce_ready", rdy_b, 1);

        // row mismatch: r=3 never driven
        @(negedge clk);
        rows = 4'b0111;
        key  = 4'b1111;
        hold = 24'd3;
        pv_a = 1'b1;
        @(negedge clk);
        pv_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("mismatch_cols", cols_a, 4'b0);
            chk("mismatch_busy", busy_a, 1);
            @(negedge clk);
        end
        chk("mismatch_done", done_a, 1);

        // busy ignores commands; accept in done cycle; zero hold
        @(negedge clk);
        rows = 4'b0011;
        key  = 4'b0110;
        hold = 24'd2;
        pv_a = 1'b1;
        @(negedge clk);
        key  = 4'b0001;
        hold = 24'd0;
        for (int i = 0; i < 6; i++) begin
            exp = (i < 2) ? 4'b0100 : 4'b0000;
            chk("hs_cols", cols_a, exp);
            chk("hs_busy", busy_a, 1);
            @(negedge clk);
        end
        chk("hs_done", done_a, 1);
        chk("hs_ready", rdy_a, 1);
        chk("hs_idle", busy_a, 0);
        @(negedge clk);
        pv_a = 1'b0;
        chk("b2b_busy", busy_a, 1);
        chk("b2b_hold0", cols_a, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_gap", cols_a, 4'b0);
            chk("b2b_gap_busy", busy_a, 1);
        end
        @(negedge clk);
        chk("b2b_done", done_a, 1);

        // asynchronous reset in the middle of HOLD
        @(negedge clk);
        rows = 4'b0010;
        key  = 4'b0110;
        hold = 24'd20;
        pv_a = 1'b1;
        @(negedge clk);
        pv_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_cols", cols_a, 4'b0100);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cols", cols_a, 4'b0);
        chk("arst_ready", rdy_a, 1);
        chk("arst_busy", busy_a, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst_no_done", done_a, 0);
            chk("arst_ready_after", rdy_a, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
